// File: rtl/add_seq_ctrl.sv
// Chunk-serial WIDTH-bit adder: one shared 16-bit full adder is walked LSB chunk first,
// with the inter-chunk carry held in a register between cycles.

module fulladd16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out
);
    assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {16'd0, c_in};
endmodule

module add_seq_ctrl #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             busy
);
    localparam int NCHUNK = WIDTH / 16;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               c_out_q, c_out_d;
    logic               ovf_q, ovf_d;

    logic [15:0]        a_chunk, b_chunk, fa_sum;
    logic               fa_cout;

    // Chunk select written as a compare-per-chunk mux so every slice index is a constant.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_chunk = a_q[16*i +: 16];
                b_chunk = b_q[16*i +: 16];
            end
        end
    end

    fulladd16 u_fa (
        .a     (a_chunk),
        .b     (b_chunk),
        .c_in  (carry_q),
        .sum   (fa_sum),
        .c_out (fa_cout)
    );

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path leaves one unassigned (no latches).
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        c_out_d   = c_out_q;
        ovf_d     = ovf_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = c_in;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                for (int i = 0; i < NCHUNK; i++) begin
                    if (idx_q == IDX_W'(i)) sum_d[16*i +: 16] = fa_sum;
                end
                carry_d = fa_cout;
                if (idx_q == LAST_IDX) begin
                    c_out_d = fa_cout;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (fa_sum[15] != a_q[WIDTH-1]);
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;  // unused code 2'b11 recovers
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule
